// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: multi-cycle A/B-register CPU with a req/ack data port, carry flag and HALT.
// Define CPU_STACK_EN to build the CALL/RET return-address stack and stack_err.
//
// state   | meaning
// FETCH   | latch IR from the instruction ROM, advance PC
// EXEC    | execute non-memory ops, or launch a data access
// MEM     | data access outstanding, waiting for dm_ack
// HALT    | stopped; only reset leaves
module multicycle_cpu_core #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int OPC_W       = 7,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ADDR_W-1:0]       im_addr,
  input  logic [OPC_W+DATA_W-1:0] im_data,
  output logic                    dm_req,
  output logic                    dm_we,
  output logic [ADDR_W-1:0]       dm_addr,
  output logic [DATA_W-1:0]       dm_wdata,
  input  logic [DATA_W-1:0]       dm_rdata,
  input  logic                    dm_ack,
  output logic [DATA_W-1:0]       alu_out_bus,
  output logic [2:0]              flags,
  output logic                    halted,
  output logic                    stack_err
);
  localparam logic [OPC_W-1:0] OP_MOV_AL = OPC_W'(7'b0000010);
  localparam logic [OPC_W-1:0] OP_MOV_BL = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OP_LD_AD  = OPC_W'(7'b0100101);
  localparam logic [OPC_W-1:0] OP_ST_DA  = OPC_W'(7'b0100111);
  localparam logic [OPC_W-1:0] OP_LD_AB  = OPC_W'(7'b0101001);
  localparam logic [OPC_W-1:0] OP_ST_BA  = OPC_W'(7'b0101011);
  localparam logic [OPC_W-1:0] OP_ADD_AD = OPC_W'(7'b0101100);
  localparam logic [OPC_W-1:0] OP_SUB_BL = OPC_W'(7'b0001011);
  localparam logic [OPC_W-1:0] OP_CMP_AB = OPC_W'(7'b1001101);
  localparam logic [OPC_W-1:0] OP_CMP_BL = OPC_W'(7'b1001111);
  localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(7'b1010011);
  localparam logic [OPC_W-1:0] OP_JEQ    = OPC_W'(7'b1010100);
  localparam logic [OPC_W-1:0] OP_JGE    = OPC_W'(7'b1011000);
  localparam logic [OPC_W-1:0] OP_JLE    = OPC_W'(7'b1011001);
  localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(7'b1111111);

  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("STACK_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  state_t state, state_nxt;

  logic [OPC_W+DATA_W-1:0] ir;
  logic [ADDR_W-1:0]       pc;
  logic [DATA_W-1:0]       a, b;
  logic                    c_f, n_f, z_f;
  logic [OPC_W-1:0]        opc;
  logic [DATA_W-1:0]       lit;
  logic [ADDR_W-1:0]       lit_addr, b_addr;
  logic                    is_mem, jmp_taken, stack_fault;
  logic [DATA_W-1:0]       sub_x, sub_y;
  logic [DATA_W:0]         sub_full, add_full;

  assign opc      = ir[OPC_W+DATA_W-1 -: OPC_W];
  assign lit      = ir[DATA_W-1:0];
  assign lit_addr = ADDR_W'(lit);
  assign b_addr   = ADDR_W'(b);
  assign im_addr  = pc;
  assign dm_req   = (state == S_MEM);
  assign halted   = (state == S_HALT);
  assign flags    = {c_f, n_f, z_f};

  // One subtractor serves SUB B,Lit and both CMPs; its MSB is the borrow (x < y unsigned).
  always_comb begin
    is_mem    = (opc == OP_LD_AD) || (opc == OP_ST_DA) || (opc == OP_LD_AB) ||
                (opc == OP_ST_BA) || (opc == OP_ADD_AD);
    jmp_taken = 1'b0;
    case (opc)
      OP_JMP:  jmp_taken = 1'b1;
      OP_JEQ:  jmp_taken = z_f;
      OP_JGE:  jmp_taken = !n_f;
      OP_JLE:  jmp_taken = n_f || z_f;
      default: jmp_taken = 1'b0;
    endcase
    sub_x    = (opc == OP_CMP_AB) ? a : b;
    sub_y    = (opc == OP_CMP_AB) ? b : lit;
    sub_full = {1'b0, sub_x} - {1'b0, sub_y};
    add_full = {1'b0, a} + {1'b0, dm_rdata};
  end

`ifdef CPU_STACK_EN
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(7'b1011010);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(7'b1011011);
  localparam int               SP_W    = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp, sp_m1;
  logic [ADDR_W-1:0] ret_addr;
  logic              stk_op;

  assign sp_m1       = sp - SP_W'(1);
  assign ret_addr    = stack_mem[sp_m1[SP_W-2:0]];
  assign stk_op      = (state == S_EXEC) && ((opc == OP_CALL) || (opc == OP_RET));
  assign stack_fault = ((opc == OP_CALL) && (sp == SP_FULL)) ||
                       ((opc == OP_RET) && (sp == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (stk_op) begin
      if (stack_fault) begin
        stack_err <= 1'b1;
      end else if (opc == OP_CALL) begin
        stack_mem[sp[SP_W-2:0]] <= pc;
        sp <= sp + SP_W'(1);
      end else begin
        sp <= sp_m1;
      end
    end
  end
`else
  assign stack_fault = 1'b0;
  assign stack_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if ((opc == OP_HALT) || stack_fault) state_nxt = S_HALT;
        else if (is_mem)                     state_nxt = S_MEM;
        else                                 state_nxt = S_FETCH;
      end
      S_MEM:   if (dm_ack) state_nxt = S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // CMP results also land on alu_out_bus as the x-y difference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir          <= '0;
      pc          <= '0;
      a           <= '0;
      b           <= '0;
      c_f         <= 1'b0;
      n_f         <= 1'b0;
      z_f         <= 1'b0;
      alu_out_bus <= '0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir <= im_data;
          pc <= pc + ADDR_W'(1);
        end
        S_EXEC: begin
          case (opc)
            OP_MOV_AL: a <= lit;
            OP_MOV_BL: b <= lit;
            OP_LD_AD, OP_ADD_AD: begin
              dm_we   <= 1'b0;
              dm_addr <= lit_addr;
            end
            OP_ST_DA: begin
              dm_we    <= 1'b1;
              dm_addr  <= lit_addr;
              dm_wdata <= a;
            end
            OP_LD_AB: begin
              dm_we   <= 1'b0;
              dm_addr <= b_addr;
            end
            OP_ST_BA: begin
              dm_we    <= 1'b1;
              dm_addr  <= b_addr;
              dm_wdata <= a;
            end
            OP_SUB_BL: begin
              b           <= sub_full[DATA_W-1:0];
              alu_out_bus <= sub_full[DATA_W-1:0];
              c_f         <= sub_full[DATA_W];
              n_f         <= sub_full[DATA_W-1];
              z_f         <= (sub_full[DATA_W-1:0] == '0);
            end
            OP_CMP_AB, OP_CMP_BL: begin
              alu_out_bus <= sub_full[DATA_W-1:0];
              c_f         <= sub_full[DATA_W];
              n_f         <= sub_full[DATA_W];
              z_f         <= (sub_full[DATA_W-1:0] == '0);
            end
            OP_JMP, OP_JEQ, OP_JGE, OP_JLE: if (jmp_taken) pc <= lit_addr;
`ifdef CPU_STACK_EN
            OP_CALL: if (!stack_fault) pc <= lit_addr;
            OP_RET:  if (!stack_fault) pc <= ret_addr;
`endif
            default: ;
          endcase
        end
        S_MEM: begin
          if (dm_ack) begin
            case (opc)
              OP_LD_AD, OP_LD_AB: a <= dm_rdata;
              OP_ADD_AD: begin
                a           <= add_full[DATA_W-1:0];
                alu_out_bus <= add_full[DATA_W-1:0];
                c_f         <= add_full[DATA_W];
                n_f         <= add_full[DATA_W-1];
                z_f         <= (add_full[DATA_W-1:0] == '0);
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
Parametrised successor of the single-cycle A/B-register computer.
- Multi-cycle FSM core (FETCH/EXEC/MEM/HALT) with configurable data width and address width.
- Data-memory port uses a req/ack handshake, so it tolerates variable-latency memory.
- Adds a carry flag, a CALL/RET return-address stack and HALT.
- Sits between the instruction ROM and the data memory/peripheral bus; top-level CPU of the next computer build.

Parameters:
DATA_W, 8, width of A, B, literal, ALU and data bus
ADDR_W, 8, width of PC, instruction address and data address
OPC_W, 7, opcode width; instruction word is OPC_W+DATA_W bits, opcode in upper bits
STACK_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
im_addr  output  ADDR_W  instruction address (= PC)
im_data  input  OPC_W+DATA_W  instruction word, combinational from im_addr
dm_req  output  1  data access request; held until dm_ack
dm_we  output  1  1=write, 0=read; valid while dm_req
dm_addr  output  ADDR_W  data address; valid while dm_req
dm_wdata  output  DATA_W  write data; valid while dm_req
dm_rdata  input  DATA_W  read data; valid in the cycle dm_ack=1
dm_ack  input  1  access completes this cycle
alu_out_bus  output  DATA_W  registered result of last flag-setting instruction
flags  output  3  {C,N,Z}
halted  output  1  core stopped
stack_err  output  1  sticky stack overflow/underflow

Behaviour:
Reset (rst_n=0 at edge):
- PC=0, A=B=0, IR=0, flags=0, alu_out_bus=0, SP=0 (empty).
- dm_req=0, halted=0, stack_err=0, state=FETCH.
- Reset overrides everything, including an in-flight dm_req; a later dm_ack for it is ignored.

FETCH (1 cycle):
- IR<=im_data; PC<=PC+1 (wraps mod 2^ADDR_W); ->EXEC.

EXEC (1 cycle):
- Non-memory instructions: complete here, ->FETCH.
- Memory instructions: drive dm_req=1 plus dm_addr/dm_we/dm_wdata, ->MEM.

MEM:
- Hold all dm_* outputs stable until dm_ack=1.
- On the ack cycle: capture dm_rdata / commit result, then ->FETCH with dm_req=0 next cycle.
- dm_ack while dm_req=0 is ignored.

Latency:
- Non-memory instruction: 2 cycles.
- Memory instruction: 3+W cycles, where W = wait cycles before ack.

Opcodes (7-bit; any other value is a NOP):
- 0000010 MOV A,Lit
- 0000011 MOV B,Lit
- 0100101 MOV A,(Dir)
- 0100111 MOV (Dir),A
- 0101001 MOV A,(B)
- 0101011 MOV (B),A
- 0101100 ADD A,(Dir): A<=A+M; C=carry out
- 0001011 SUB B,Lit: B<=B-Lit; C=borrow
- 1001101 CMP A,B: flags only
- 1001111 CMP B,Lit: flags only
- 1010011 JMP
- 1010100 JEQ (Z=1)
- 1011000 JGE (N=0)
- 1011001 JLE (N=1 or Z=1)
- 1011010 CALL
- 1011011 RET
- 1111111 HALT

Arithmetic and flags:
- All arithmetic is modulo 2^DATA_W; Z=(result==0); N=result[DATA_W-1].
- CMP sets Z=(x==y) and N=C=(x<y unsigned).
- MOV and jumps leave flags and alu_out_bus unchanged.
- Literal is the low DATA_W bits of IR. A jump target or Dir wider than ADDR_W is truncated; a narrower one is zero-extended.
- Jumps taken in EXEC: PC<=target. Not taken: PC unchanged.

CALL / RET:
- CALL: push PC (already incremented), PC<=Lit.
- RET: pop into PC.
- Overflow (CALL with SP=STACK_DEPTH) or underflow (RET with SP=0): no push/pop, stack_err<=1, ->HALT.

HALT state:
- Entered after EXEC of HALT or on a stack error.
- halted=1, no fetch, PC frozen; leave only via reset.

Optional Feature:
Macro CPU_STACK_EN.
- Defined: return-address stack, CALL, RET and stack_err exist as specified.
- Undefined: no stack storage is built; CALL and RET decode as NOP (2 cycles); stack_err is tied to 0.

Test Plan:
- MOV A,5; MOV B,3; CMP A,B; HALT with dm_ack tied 1 -> flags=000, halted=1 at cycle 8, A=5, B=3.
- MOV A,0x80; MOV (0x10),A; MOV A,0x80; ADD A,(0x10), memory ack delayed 3 cycles -> dm_req stays high 4 cycles with stable addr 0x10; then A=0x00, Z=1, C=1, N=0, alu_out_bus=0x00.
- MOV B,2; SUB B,3 -> B=0xFF, N=1, C=1, Z=0; then CMP B,0xFF; JEQ 0x20 -> PC=0x20.
- CALL 0x10 at addr 0; RET at 0x10 -> PC returns to 1. Five nested CALLs (STACK_DEPTH=4) -> stack_err=1, halted=1, PC frozen. With CPU_STACK_EN undefined, same program runs CALLs as NOPs.
- Assert rst_n=0 mid-MEM with dm_req=1 -> next cycle dm_req=0, PC=0, A=B=0, flags=0. A stray dm_ack afterwards has no effect.
- DATA_W=16, ADDR_W=10: MOV A,0xFFFF; MOV (0x3FF),A; ADD A,(0x3FF) -> A=0xFFFE, C=1, N=1. PC wraps 0x3FF->0x000 on fetch.
